// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity modes, receiver state encoding and baud divider rounding.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;
  function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
    return int'((clk_hz + (baud * os) / 2) / (baud * os));
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle oversample enable every round(CLK_HZ/(BAUD*OVERSAMPLE)) clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic CLK50MHz,
  input  logic RESET,
  output logic tick_en
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  logic [CW-1:0] cnt;
  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: divider below 2");
  end
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) cnt <= '0;
    else cnt <= tick_en ? '0 : cnt + 1'b1;
  assign tick_en = cnt == CW'(DIV - 1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, parity/framing checks,
// valid/ready hand-off and sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK50MHz,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SMP_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8) begin : g_os_chk
    $error("uart_rx_param: OVERSAMPLE must be at least 8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  state_t               state, state_n;
  logic [SW-1:0]        scnt, scnt_n;
  logic [3:0]           bidx, bidx_n;
  logic                 sidx, sidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 s0, s0_n, s1, s1_n;
  logic                 perr, perr_n, ferr, ferr_n;
  logic                 done, tick, mpt, last;
  logic                 rx_m, rx_s, rx_prev, fall, maj, exp_par;
  logic [2:0]           warm;
  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .CLK50MHz(CLK50MHz),
    .RESET   (RESET),
    .tick_en (tick)
  );
  // warm keeps the reset value of the synchroniser from posing as a falling edge
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) begin
      {rx_m, rx_s, rx_prev} <= 3'b111;
      warm <= '0;
    end else begin
      rx_m    <= RX;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      warm    <= {warm[1:0], 1'b1};
    end
  assign fall    = warm[2] & rx_prev & ~rx_s;
  assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign exp_par = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign mpt     = tick && scnt == SMP_HI;
  assign last    = tick && scnt == SMP_LAST;
  assign BUSY    = state != ST_IDLE;
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) begin
      state <= ST_IDLE;
      scnt  <= '0;
      bidx  <= '0;
      sidx  <= 1'b0;
      shreg <= '0;
      s0    <= 1'b1;
      s1    <= 1'b1;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      bidx  <= bidx_n;
      sidx  <= sidx_n;
      shreg <= shreg_n;
      s0    <= s0_n;
      s1    <= s1_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bidx_n  = bidx;
    sidx_n  = sidx;
    shreg_n = shreg;
    s0_n    = s0;
    s1_n    = s1;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;
    if (state == ST_IDLE) begin
      if (fall) begin
        state_n = ST_START;
        scnt_n  = '0;
        bidx_n  = '0;
        sidx_n  = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
      end
    end else if (state == ST_WAIT_HIGH) begin
      state_n = rx_s ? ST_IDLE : ST_WAIT_HIGH;
    end else if (tick) begin
      scnt_n = last ? '0 : scnt + 1'b1;
      s0_n   = (scnt == SMP_LO) ? rx_s : s0;
      s1_n   = (scnt == SMP_MID) ? rx_s : s1;
      case (state)
        ST_START:
          state_n = (mpt && maj) ? ST_IDLE : last ? ST_DATA : state;
        ST_DATA: begin
          shreg_n = mpt ? {maj, shreg[DATA_BITS-1:1]} : shreg;
          bidx_n  = last ? bidx + 4'd1 : bidx;
          if (last && bidx == 4'(DATA_BITS - 1))
            state_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: begin
          perr_n  = mpt ? (maj != exp_par) : perr;
          state_n = last ? ST_STOP : state;
        end
        ST_STOP: begin
          ferr_n = mpt ? (ferr | ~maj) : ferr;
          sidx_n = last ? sidx + 1'b1 : sidx;
          if (mpt && sidx == 1'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_n = (ferr | ~maj) ? ST_WAIT_HIGH : ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end
  // a completed frame only replaces the held word once the consumer has it
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) begin
      DATA       <= '0;
      VALID      <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (done && (!VALID || READY)) begin
        DATA       <= shreg;
        PARITY_ERR <= perr;
        FRAME_ERR  <= ferr_n;
        VALID      <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
      OVERRUN <= (done && VALID && !READY) ? 1'b1 : (VALID && READY) ? 1'b0 : OVERRUN;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a frame-level model of the receiver.
module tb_uart_rx_param;
  localparam int OS   = 8;
  localparam int DIV  = 3;
  localparam int BITC = OS * DIV;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, perr, ferr, ovr, busy;
  int         tests = 0;
  int         fails = 0;
  logic [9:0] cap [64];
  int         cap_n = 0;
  int         busy_cnt = 0;
  logic       mon_en = 1'b1;
  always #5 clk = ~clk;
  uart_rx_param #(
    .CLK_HZ    (2400000),
    .BAUD      (100000),
    .DATA_BITS (8),
    .PARITY    (2),
    .STOP_BITS (1),
    .OVERSAMPLE(OS)
  ) dut (
    .CLK50MHz  (clk),
    .RESET     (rst_n),
    .RX        (rx),
    .DATA      (data),
    .VALID     (valid),
    .READY     (ready),
    .PARITY_ERR(perr),
    .FRAME_ERR (ferr),
    .OVERRUN   (ovr),
    .BUSY      (busy)
  );
  always @(negedge clk) begin
    if (mon_en && valid) begin
      cap[cap_n[5:0]] <= {ferr, perr, data};
      cap_n <= cap_n + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic even_bit(input logic [7:0] d);
    return 1'($countones(d) % 2);
  endfunction
  task automatic send_bits(input logic b, input int n);
    rx = b;
    repeat (n * BITC) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(d[i], 1);
    send_bits(p, 1);
    send_bits(s, 1);
    send_bits(1'b1, 2);
  endtask
  task automatic frame_check(input string tag, input logic [7:0] d, input logic p, input logic s);
    int base;
    base = cap_n;
    send_frame(d, p, s);
    check({tag, "_count"}, 16'(cap_n - base), 16'd1);
    check({tag, "_word"}, 16'(cap[base[5:0]]), 16'({~s, p != even_bit(d), d}));
  endtask
  initial begin
    int         base, b0;
    logic [7:0] d;
    logic       bad_p, bad_s;
    repeat (4) @(negedge clk);
    check("reset_outs", 16'({data, valid, perr, ferr, ovr, busy}), 16'd0);
    rst_n = 1'b1;
    send_bits(1'b1, 2);
    frame_check("f55", 8'h55, 1'b0, 1'b1);
    frame_check("a3_badpar", 8'hA3, 1'b1, 1'b1);
    frame_check("a3_goodpar", 8'hA3, 1'b0, 1'b1);
    base = cap_n;
    b0 = busy_cnt;
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    send_bits(1'b1, 2);
    check("glitch_busy_seen", 16'(busy_cnt > b0), 16'd1);
    check("glitch_busy_short", 16'(busy_cnt - b0 < BITC), 16'd1);
    check("glitch_idle", 16'(busy), 16'd0);
    check("glitch_no_valid", 16'(cap_n - base), 16'd0);
    base = cap_n;
    send_bits(1'b0, 33);
    check("break_count", 16'(cap_n - base), 16'd1);
    check("break_word", 16'(cap[base[5:0]]), 16'({1'b1, 1'b0, 8'h00}));
    check("break_wait_high", 16'(busy), 16'd1);
    send_bits(1'b1, 2);
    check("break_no_more", 16'(cap_n - base), 16'd1);
    check("break_released", 16'(busy), 16'd0);
    frame_check("after_break", 8'h5A, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      d     = 8'($urandom_range(0, 255));
      bad_p = ($urandom_range(0, 3) == 0);
      bad_s = ($urandom_range(0, 4) == 0);
      frame_check($sformatf("rnd%0d", k), d, even_bit(d) ^ bad_p, ~bad_s);
    end
    mon_en = 1'b0;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    check("ovr_first_valid", 16'(valid), 16'd1);
    check("ovr_first_data", 16'(data), 16'h11);
    check("ovr_first_flag", 16'(ovr), 16'd0);
    send_frame(8'h22, 1'b0, 1'b1);
    check("ovr_held_data", 16'(data), 16'h11);
    check("ovr_set", 16'(ovr), 16'd1);
    check("ovr_still_valid", 16'(valid), 16'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_valid_clr", 16'(valid), 16'd0);
    check("ovr_flag_clr", 16'(ovr), 16'd0);
    ready = 1'b1;
    mon_en = 1'b1;
    base = cap_n;
    d = 8'h3C;
    send_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bits(d[i], 1);
    rx = d[4];
    repeat (BITC / 2) @(negedge clk);
    check("rst_mid_busy", 16'(busy), 16'd1);
    #3 rst_n = 1'b0;
    #1 check("rst_async_outs", 16'({data, valid, perr, ferr, ovr, busy}), 16'd0);
    rx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(1'b0, 1);
    check("rst_low_not_start", 16'(busy), 16'd0);
    check("rst_no_valid", 16'(cap_n - base), 16'd0);
    send_bits(1'b1, 1);
    frame_check("after_rst_3c", 8'h3C, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
